// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_pkg
// Brief    : Command codes, status identifier and FSM state type shared by
//            the SPI register-interface responder.
// Revision : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h2F;
    localparam logic [7:0] CMD_READ   = 8'h3F;
    localparam logic [7:0] CMD_STATUS = 8'hF0;
    localparam logic [6:0] STATUS_ID  = 7'b1010_000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        WRITE  = 3'd2,
        READ   = 3'd3,
        STATUS = 3'd4,
        DRAIN  = 3'd5
    } spi_state_t;

endpackage : spi_slave_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Brief    : Multi-flop synchronizer for one asynchronous SPI input, plus a
//            single-cycle rise/fall detector on the synchronized level.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw input through the synchronizer chain and keep the
    // previous synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign dout = r_sync[SYNC_STAGES-1];
    assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave_regif.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_regif
// Brief    : SPI mode-0 responder giving burst write/read access to a
//            DEPTH x 8 register file, with a status command and sticky
//            unknown-command flag. SPI pins are oversampled by clk.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_regif
    import spi_slave_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_cs_n,
    input  logic                     spi_sck,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic                     spi_miso_oe,
    output logic                     wr_valid,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data,
    output logic                     cmd_err
);

    localparam int AW = $clog2(DEPTH);

    logic w_cs_n_sync, w_cs_rise, w_cs_fall;
    logic w_sck_sync, w_sck_rise, w_sck_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
        .dout(w_cs_n_sync), .rise(w_cs_rise), .fall(w_cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .din(spi_sck),
        .dout(w_sck_sync), .rise(w_sck_rise), .fall(w_sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .dout(w_mosi_sync), .rise(w_mosi_rise), .fall(w_mosi_fall)
    );

    // Levels/edges the FSM does not need; the enable is tracked by state.
    logic w_unused;
    assign w_unused = &{1'b0, w_cs_n_sync, w_sck_sync, w_mosi_rise, w_mosi_fall};

    spi_state_t      r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_rx;
    logic [7:0]      r_tx;
    logic [AW-1:0]   r_addr;
    logic            r_miso;
    logic            r_oe;
    logic            r_wr_valid;
    logic [AW-1:0]   r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            r_cmd_err;
    logic [7:0]      r_regs [DEPTH];

    logic [7:0] w_rx_next;
    logic [7:0] w_status;

    assign w_rx_next = {r_rx[6:0], w_mosi_sync};
    assign w_status  = {STATUS_ID, r_cmd_err};

    // Transaction FSM: byte assembly on sck rise, tx shifting on sck fall,
    // command decode and register-file access at each completed byte.
    // The byte-done branch runs before the cs_n-rise override so a byte
    // finishing in the same cycle as deselect is still committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx       <= 8'h00;
            r_tx       <= 8'h00;
            r_addr     <= '0;
            r_miso     <= 1'b0;
            r_oe       <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'h00;
            r_cmd_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_wr_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_cs_fall) begin
                    r_state   <= CMD;
                    r_bit_cnt <= 3'd0;
                    r_addr    <= '0;
                    r_tx      <= 8'h00;
                    r_miso    <= 1'b0;
                    r_oe      <= 1'b1;
                end
            end else begin
                if (w_sck_rise) begin
                    r_rx      <= w_rx_next;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        case (r_state)
                            CMD: begin
                                if (w_rx_next == CMD_WRITE) begin
                                    r_state <= WRITE;
                                    r_tx    <= 8'h00;
                                    r_miso  <= 1'b0;
                                end else if (w_rx_next == CMD_READ) begin
                                    r_state <= READ;
                                    r_tx    <= r_regs[0];
                                    r_miso  <= r_regs[0][7];
                                    r_addr  <= AW'(1);
                                end else if (w_rx_next == CMD_STATUS) begin
                                    r_state   <= STATUS;
                                    r_tx      <= w_status;
                                    r_miso    <= w_status[7];
                                    r_cmd_err <= 1'b0;
                                end else begin
                                    r_state   <= DRAIN;
                                    r_tx      <= 8'h00;
                                    r_miso    <= 1'b0;
                                    r_cmd_err <= 1'b1;
                                end
                            end
                            WRITE: begin
                                r_regs[r_addr] <= w_rx_next;
                                r_wr_valid     <= 1'b1;
                                r_wr_addr      <= r_addr;
                                r_wr_data      <= w_rx_next;
                                r_addr         <= r_addr + AW'(1);
                            end
                            READ: begin
                                r_tx   <= r_regs[r_addr];
                                r_miso <= r_regs[r_addr][7];
                                r_addr <= r_addr + AW'(1);
                            end
                            STATUS: begin
                                r_state <= DRAIN;
                                r_tx    <= 8'h00;
                                r_miso  <= 1'b0;
                            end
                            default: begin
                                r_tx   <= 8'h00;
                                r_miso <= 1'b0;
                            end
                        endcase
                    end
                end else if (w_sck_fall && (r_bit_cnt != 3'd0)) begin
                    // No shift on the fall after a byte load: the new MSB
                    // must stay on the line until the next byte's first rise.
                    r_tx   <= {r_tx[6:0], 1'b0};
                    r_miso <= r_tx[6];
                end
                if (w_cs_rise) begin
                    r_state   <= IDLE;
                    r_bit_cnt <= 3'd0;
                    r_miso    <= 1'b0;
                    r_oe      <= 1'b0;
                end
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_oe;
    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign cmd_err     = r_cmd_err;
    assign rd_data     = r_regs[rd_addr];

endmodule : spi_slave_regif
`default_nettype wire

// File: tb/tb_spi_slave_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_regif
// Brief    : Directed self-checking bench for spi_slave_regif: an SPI mode-0
//            master model at f_clk = 10 * f_sck with table-driven expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_regif;

    logic       clk;
    logic       rst_n;
    logic       spi_cs_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       wr_valid;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       cmd_err;

    spi_slave_regif #(.DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t       tbl [10];
    logic [7:0] tx_buf [16];
    logic [7:0] rx_buf [16];
    logic [2:0] q_addr [$];
    logic [7:0] q_data [$];
    int         errors = 0;
    int         checks = 0;

    // Collect every write pulse for later comparison.
    always @(negedge clk) begin
        if (wr_valid) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One SPI byte (or the first nbits of it), MSB first, mode 0.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = tx[i];
            #50;
            rx = {rx[6:0], spi_miso};
            spi_sck = 1'b1;
            #50;
            spi_sck = 1'b0;
        end
    endtask

    // Full transaction of n bytes from tx_buf; the last may be truncated.
    task automatic xact(input int n, input int last_bits);
        spi_cs_n = 1'b0;
        #100;
        chk("oe_active", {31'd0, spi_miso_oe}, 32'd1);
        for (int i = 0; i < n; i++) begin
            xfer(tx_buf[i], (i == n - 1) ? last_bits : 8, rx_buf[i]);
        end
        #100;
        spi_cs_n = 1'b1;
        #200;
        chk("oe_idle", {31'd0, spi_miso_oe}, 32'd0);
        chk("miso_idle", {31'd0, spi_miso}, 32'd0);
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < 8; i++) begin
            rd_addr = tbl[i].addr;
            #1;
            chk($sformatf("%s_reg%0d", name, i), {24'd0, rd_data}, {24'd0, tbl[i].data});
        end
    endtask

    task automatic fill_tbl(input logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7);
        tbl[0] = '{3'd0, d0}; tbl[1] = '{3'd1, d1};
        tbl[2] = '{3'd2, d2}; tbl[3] = '{3'd3, d3};
        tbl[4] = '{3'd4, d4}; tbl[5] = '{3'd5, d5};
        tbl[6] = '{3'd6, d6}; tbl[7] = '{3'd7, d7};
    endtask

    initial begin
        rst_n    = 1'b0;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        rd_addr  = 3'd0;
        #47;
        // Reset state.
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_wr_addr", {29'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        fill_tbl(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_regs("rst");
        rst_n = 1'b1;
        #100;

        // sck activity with cs_n high must be ignored.
        spi_mosi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #50 spi_sck = 1'b1;
            #50 spi_sck = 1'b0;
        end
        spi_mosi = 1'b0;
        #100;
        chk("nocs_writes", q_addr.size(), 32'd0);
        chk("nocs_oe", {31'd0, spi_miso_oe}, 32'd0);
        chk("nocs_cmd_err", {31'd0, cmd_err}, 32'd0);

        // Burst write of 8 bytes.
        tx_buf[0] = 8'h2F;
        for (int i = 0; i < 8; i++) tx_buf[i + 1] = 8'((i % 4) + 1);
        xact(9, 8);
        fill_tbl(8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04);
        chk("wr_pulses", q_addr.size(), 32'd8);
        for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
            chk($sformatf("wr_addr%0d", i), {29'd0, q_addr[i]}, {29'd0, tbl[i].addr});
            chk($sformatf("wr_data%0d", i), {24'd0, q_data[i]}, {24'd0, tbl[i].data});
        end
        check_regs("wr");

        // Burst read: command byte returns 00, then reg[0..7].
        tx_buf[0] = 8'h3F;
        for (int i = 1; i < 9; i++) tx_buf[i] = 8'hC5;
        xact(9, 8);
        chk("rd_byte0", {24'd0, rx_buf[0]}, 32'h00);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rd_byte%0d", i + 1), {24'd0, rx_buf[i + 1]}, {24'd0, tbl[i].data});
        end
        rd_addr = 3'd3;
        #1;
        chk("rd_data_a3", {24'd0, rd_data}, 32'h04);

        // Unknown command, then two status reads.
        tx_buf[0] = 8'h55; tx_buf[1] = 8'hFF;
        xact(2, 8);
        chk("drain_miso", {24'd0, rx_buf[1]}, 32'h00);
        chk("cmd_err_set", {31'd0, cmd_err}, 32'd1);
        tx_buf[0] = 8'hF0; tx_buf[1] = 8'h00;
        xact(2, 8);
        chk("status1", {24'd0, rx_buf[1]}, 32'hA1);
        chk("cmd_err_clr", {31'd0, cmd_err}, 32'd0);
        xact(2, 8);
        chk("status2", {24'd0, rx_buf[1]}, 32'hA0);

        // Partial trailing byte is discarded.
        q_addr.delete(); q_data.delete();
        tx_buf[0] = 8'h2F; tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB;
        xact(3, 4);
        chk("part_pulses", q_addr.size(), 32'd1);
        fill_tbl(8'hAA, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04);
        check_regs("part");
        tx_buf[0] = 8'h3F; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        xact(3, 8);
        chk("part_rd0", {24'd0, rx_buf[1]}, 32'hAA);
        chk("part_rd1", {24'd0, rx_buf[2]}, 32'h02);

        // Address wrap: 10 data bytes into 8 registers.
        q_addr.delete(); q_data.delete();
        tx_buf[0] = 8'h2F;
        for (int i = 0; i < 10; i++) tx_buf[i + 1] = 8'h10 + 8'(i);
        xact(11, 8);
        chk("wrap_pulses", q_addr.size(), 32'd10);
        if (q_addr.size() == 10) begin
            chk("wrap_last_addr", {29'd0, q_addr[9]}, 32'd1);
            chk("wrap_last_data", {24'd0, q_data[9]}, 32'h19);
        end
        fill_tbl(8'h18, 8'h19, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17);
        check_regs("wrap");

        // Reset in the middle of a read burst.
        spi_cs_n = 1'b0;
        #100;
        xfer(8'h3F, 8, rx_buf[0]);
        xfer(8'h00, 8, rx_buf[1]);
        xfer(8'h00, 8, rx_buf[2]);
        chk("mid_rd_byte", {24'd0, rx_buf[2]}, 32'h19);
        rst_n = 1'b0;
        #1;
        chk("mrst_miso", {31'd0, spi_miso}, 32'd0);
        chk("mrst_oe", {31'd0, spi_miso_oe}, 32'd0);
        chk("mrst_wr_addr", {29'd0, wr_addr}, 32'd0);
        chk("mrst_wr_data", {24'd0, wr_data}, 32'd0);
        fill_tbl(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_regs("mrst");
        #50;
        spi_cs_n = 1'b1;
        #100;
        rst_n = 1'b1;
        #100;
        tx_buf[0] = 8'h3F;
        for (int i = 1; i < 4; i++) tx_buf[i] = 8'hFF;
        xact(4, 8);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("post_rst_rd%0d", i), {24'd0, rx_buf[i]}, 32'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_spi_slave_regif
`default_nettype wire
